window_scan_ctrl: RTL
=====================

Name: window_scan_ctrl

Overview:
Sequences the sliding-window line buffer in the HOG front end.
- Tracks pixel column and row of the incoming stream.
- Clears the buffer fill counter at frame start.
- Asserts window-valid only when a full WIN x WIN neighbourhood sits in the line buffer.
- Reports line end, frame completion and an optional overrun condition to the downstream gradient/histogram stages.

Parameters:
IMG_W, 38, pixels per line
IMG_H, 30, lines per frame
WIN, 3, window edge in pixels (line buffer holds (WIN-1)*IMG_W+(WIN-1) = 78 at defaults)

Ports:
clk  in  1  the clock
rst  in  1  reset, asynchronous, active-low
i_sof  in  1  frame start pulse; accepted in any state
i_valid  in  1  input pixel valid, one pixel per asserted cycle
o_buf_clear  out  1  one-cycle clear to line buffer fill counter
o_win_valid  out  1  current pixel completes a valid window
o_col  out  $clog2(IMG_W)  column of the current accepted pixel
o_row  out  $clog2(IMG_H)  row of the current accepted pixel
o_line_end  out  1  current accepted pixel is at col IMG_W-1
o_frame_done  out  1  one-cycle pulse after the last pixel of the frame
o_busy  out  1  state is not IDLE
o_overrun  out  1  sticky overrun flag (see Optional Feature)

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; col=0, row=0. All outputs 0.
- States and transitions:
  - IDLE: waits for i_sof.
  - FILL: row<WIN-1.
  - RUN: row>=WIN-1.
  - DONE: single cycle, then IDLE.
- i_sof handling:
  - i_sof in any state: next state FILL, col=0, row=0, o_buf_clear=1 for exactly that one cycle.
  - A pixel presented in the same cycle as i_sof is discarded (the clear wins).
- Counters:
  - col increments on each i_valid in FILL/RUN.
  - At col=IMG_W-1 with i_valid: col wraps to 0 and row increments.
  - i_valid in IDLE/DONE does not advance counters.
- Combinational outputs, qualified by i_valid, same cycle as the pixel:
  - o_col/o_row show the pre-increment position of the accepted pixel.
  - o_line_end = i_valid & (col==IMG_W-1).
  - o_win_valid = i_valid & state==RUN & col>=WIN-1.
- FILL to RUN: on the wrap out of row WIN-2.
- RUN to DONE: on i_valid at col=IMG_W-1, row=IMG_H-1. o_frame_done=1 in the DONE cycle (registered, latency 1).
- Valid-pixel counts (no stalls):
  - First o_win_valid is the ((WIN-1)*IMG_W+WIN)-th accepted pixel, i.e. the 79th at defaults.
  - Windows per frame = (IMG_H-WIN+1)*(IMG_W-WIN+1) = 28*36 = 1008.
- Gaps in i_valid are allowed anywhere: counters and state hold.
- Arithmetic: counters are unsigned, width from $clog2. All comparisons use full-width constants. Counters never exceed IMG_W-1 / IMG_H-1.
- Reset mid-frame: immediate return to reset values; no o_frame_done is emitted.

Optional Feature:
Macro: SCAN_OVERRUN_DET_EN
- Enabled: o_overrun is a sticky flag.
  - Sets on any i_valid while in DONE or IDLE after at least one completed frame.
  - Clears only on rst or i_sof; i_sof takes priority over a same-cycle set.
- Disabled: o_overrun is tied to 0, and extra pixels are silently ignored.

Decomposition:
- Shared package hog_pkg holds:
  - scan_state_t enum: IDLE, FILL, RUN, DONE.
  - Width constants COL_W=$clog2(IMG_W) and ROW_W=$clog2(IMG_H).
  - Fill depth constant BUF_DEPTH=(WIN-1)*IMG_W+(WIN-1), shared with the buffer counter.
- One sub-module: wrap_counter (parameter MAX, inputs en/clr, outputs value and wrap), instantiated twice for col and row.

Test Plan:
- Reset: rst=0 mid-stream -> all outputs 0 immediately, state IDLE; release then i_valid without i_sof -> no counter change.
- Nominal frame: i_sof then 1140 contiguous i_valid -> o_buf_clear one cycle; first o_win_valid on pixel 79 (row 2, col 2); 1008 windows total; o_frame_done one cycle after pixel 1140.
- Gapped stream: i_valid random 50% -> same 1008 windows at identical (row,col) positions; o_line_end exactly 30 times.
- Restart: i_sof at pixel 500 -> counters reset to 0, second o_buf_clear, no o_frame_done for the aborted frame; the following full frame behaves nominally.
- Same-cycle i_sof and i_valid -> that pixel is discarded, col=0 on the next accepted pixel.
- SCAN_OVERRUN_DET_EN defined: 3 extra i_valid after frame end -> o_overrun=1 and held; next i_sof -> 0. Undefined: o_overrun stays 0.

Source files
------------

// File: rtl/hog_pkg.sv
// Shared types and sizing for the HOG front-end window scan logic.
// Default image geometry, counter widths and the line-buffer fill depth.
package hog_pkg;

    localparam int IMG_W_DEF = 38;
    localparam int IMG_H_DEF = 30;
    localparam int WIN_DEF   = 3;

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int COL_W     = cnt_w(IMG_W_DEF);
    localparam int ROW_W     = cnt_w(IMG_H_DEF);
    localparam int BUF_DEPTH = (WIN_DEF - 1) * IMG_W_DEF + (WIN_DEF - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } scan_state_t;

endpackage

// File: rtl/window_scan_ctrl_if.sv
// Pixel-stream handshake and scan status bundle for window_scan_ctrl.
// master drives the stream (source side); slave is the scan controller.
interface window_scan_ctrl_if #(
    parameter int COL_W = hog_pkg::COL_W,
    parameter int ROW_W = hog_pkg::ROW_W
);
    logic             i_sof;
    logic             i_valid;
    logic             o_buf_clear;
    logic             o_win_valid;
    logic [COL_W-1:0] o_col;
    logic [ROW_W-1:0] o_row;
    logic             o_line_end;
    logic             o_frame_done;
    logic             o_busy;
    logic             o_overrun;

    modport master (
        output i_sof, i_valid,
        input  o_buf_clear, o_win_valid, o_col, o_row, o_line_end,
               o_frame_done, o_busy, o_overrun
    );

    modport slave (
        input  i_sof, i_valid,
        output o_buf_clear, o_win_valid, o_col, o_row, o_line_end,
               o_frame_done, o_busy, o_overrun
    );
endinterface

// File: rtl/wrap_counter.sv
// Modulo (MAX+1) counter with synchronous clear; o_wrap flags the enabled
// step out of MAX so a cascaded counter can use it as its enable.
module wrap_counter #(
    parameter int MAX = 1,
    parameter int W   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic         i_clr,
    output logic [W-1:0] o_value,
    output logic         o_wrap
);
    logic [W-1:0] r_value;

    assign o_wrap  = i_en & (r_value == W'(MAX));
    assign o_value = r_value;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_value <= '0;
        end else if (i_clr) begin
            r_value <= '0;
        end else if (o_wrap) begin
            r_value <= '0;
        end else if (i_en) begin
            r_value <= r_value + W'(1);
        end
    end
endmodule

// File: rtl/window_scan_ctrl.sv
// Column/row sequencer for the sliding-window line buffer of the HOG front end.
// Optional sticky overrun detection is built when SCAN_OVERRUN_DET_EN is defined.
module window_scan_ctrl
    import hog_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int WIN   = WIN_DEF
) (
    input  logic               clk,
    input  logic               rst,
    window_scan_ctrl_if.slave  bus
);
    localparam int CW = cnt_w(IMG_W);
    localparam int RW = cnt_w(IMG_H);

    scan_state_t   r_state;
    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic          w_col_wrap;
    logic          w_row_wrap;
    logic          w_accept;

    // A pixel arriving with i_sof belongs to no frame: the clear wins.
    assign w_accept = bus.i_valid & ~bus.i_sof &
                      ((r_state == FILL) | (r_state == RUN));

    wrap_counter #(.MAX(IMG_W - 1), .W(CW)) u_col (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_accept),
        .i_clr   (bus.i_sof),
        .o_value (w_col),
        .o_wrap  (w_col_wrap)
    );

    wrap_counter #(.MAX(IMG_H - 1), .W(RW)) u_row (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_col_wrap),
        .i_clr   (bus.i_sof),
        .o_value (w_row),
        .o_wrap  (w_row_wrap)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else if (bus.i_sof) begin
            r_state <= FILL;
        end else begin
            case (r_state)
                IDLE: r_state <= IDLE;
                FILL: if (w_col_wrap && (w_row == RW'(WIN - 2))) r_state <= RUN;
                RUN:  if (w_row_wrap) r_state <= DONE;
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Reset gating keeps the clear quiet while rst is held low.
    assign bus.o_buf_clear  = bus.i_sof & rst;
    assign bus.o_col        = w_accept ? w_col : '0;
    assign bus.o_row        = w_accept ? w_row : '0;
    assign bus.o_line_end   = w_col_wrap;
    assign bus.o_win_valid  = w_accept & (r_state == RUN) & (w_col >= CW'(WIN - 1));
    assign bus.o_frame_done = (r_state == DONE);
    assign bus.o_busy       = (r_state != IDLE);

`ifdef SCAN_OVERRUN_DET_EN
    logic r_overrun;
    logic r_frame_seen;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overrun    <= 1'b0;
            r_frame_seen <= 1'b0;
        end else begin
            if (r_state == DONE) r_frame_seen <= 1'b1;
            if (bus.i_sof) begin
                r_overrun <= 1'b0;
            end else if (bus.i_valid &&
                         ((r_state == DONE) || ((r_state == IDLE) && r_frame_seen))) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign bus.o_overrun = r_overrun;
`else
    assign bus.o_overrun = 1'b0;
`endif

endmodule
